map_painter: RTL and testbench
==============================

# map_painter

Rectangle fill engine that writes into the byte-packed terrain map memory read by the dino/map renderer. The map is 512 bytes wide (4096 pixels) by 1024 rows. Each byte holds 8 horizontally adjacent pixels, and the LSB is the leftmost pixel. The block accepts one rectangle at a time and sets or clears every pixel inside it. Bytes fully covered by the rectangle are written directly; partially covered bytes use read-modify-write.

## Interface
Parameters: none. The map geometry is fixed at 512 bytes × 1024 rows.

Ports:
- Clk  in  1  system clock (50 MHz); one clock domain
- Reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request; high only in IDLE
- req_x  in  12  left pixel column, absolute map coordinates (not screen/shifted)
- req_y  in  10  top row
- req_w  in  12  width in pixels
- req_h  in  10  height in rows
- req_set  in  1  1 = set pixels, 0 = clear pixels
- mem_addr  out  19  byte address = {row, 9'b0} + byte_col
- mem_re  out  1  read strobe; mem_rdata is valid the following cycle
- mem_rdata  in  8  read data from the map RAM
- mem_we  out  1  write strobe
- mem_wdata  out  8  write data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a request completes

## Operation
- **Request acceptance**
  - A request is accepted on a cycle where req_valid && req_ready.
  - All req_* inputs are latched on that cycle; later changes are ignored.
- **Clipping**
  - Effective last column: lx = min(req_x + req_w, 4096) − 1.
  - Effective last row: ly = min(req_y + req_h, 1024) − 1.
  - Compute these sums at 13/11 bits so they cannot overflow.
- **Empty request**
  - If req_w == 0, req_h == 0, or the clipped extent is empty, go to DONE with no memory access.
- **Scan order**
  - Rows run from req_y to ly.
  - Within a row, byte_col runs from req_x[11:3] to lx[11:3].
- **Byte mask**
  - Low bit lo = req_x[2:0] on the first byte of the row, otherwise 0.
  - High bit hi = lx[2:0] on the last byte of the row, otherwise 7.
  - mask = bits lo..hi set.
- **States**
  - IDLE: req_ready = 1. On accept go to CHECK, or to DONE if the request is empty.
  - CHECK (combinational, same cycle as the byte op):
    - If mask == 8'hFF, act as WRITE_FULL: mem_we = 1, mem_wdata = req_set ? 8'hFF : 8'h00.
    - Otherwise go to READ.
  - READ: mem_re = 1, mem_addr = current byte. Next state is MODIFY.
  - MODIFY: mem_we = 1, same mem_addr, mem_wdata = req_set ? (mem_rdata | mask) : (mem_rdata & ~mask).
  - Advance after each write:
    - Move to the next byte.
    - At the end of a row, wrap to the first byte of the next row.
    - After the last byte of row ly, go to DONE.
  - DONE: done = 1 for one cycle, then IDLE.
- **Strobe exclusivity**
  - mem_re and mem_we are never high in the same cycle.
  - mem_addr is don't-care when both strobes are low.
- **Reset behaviour**
  - Reset in any state returns to IDLE on that edge.
  - A byte whose read has been issued is not written.
  - No done pulse is produced.

## Timing
- **Reset values (cycle after Reset)**
  - state IDLE, req_ready 1, busy 0, done 0, mem_re 0, mem_we 0.
  - mem_addr 0, mem_wdata 0.
- **Byte costs**
  - Full byte: 1 cycle.
  - Partial byte: 2 cycles (READ, then MODIFY).
- **Latency**
  - Accept at cycle T0; the first byte operation is at T1.
  - Total cycles = rows × (full_bytes + 2 × partial_bytes).
  - done is asserted the cycle after the final write.
  - req_ready returns high the cycle after done.
- **Busy / ready**
  - busy is high from T1 through the done cycle inclusive.
  - req_ready is 0 while busy.
- **Throughput**
  - One request in flight; no queueing.
  - Back-to-back requests are separated by at least the done cycle.

## Test plan
- **Single pixel set:** x=10, y=3, w=1, h=1, set=1, RAM byte 1537 = 8'h81.
  - T1: READ at addr 1537.
  - T2: WRITE at addr 1537 with wdata 8'h85.
  - T3: done pulse.
- **Aligned clear:** x=16, w=16, y=0, h=2, set=0.
  - Exactly 4 writes of 8'h00, to addrs 2, 3, 514, 515, on T1–T4.
  - mem_re never asserted; done at T5.
- **Straddling span:** x=5, w=8, y=0, h=1, set=1, RAM all 8'h00.
  - Writes 8'hE0 to addr 0, then 8'h1F to addr 1.
  - 4 cycles of memory activity.
- **Clipping:** x=4090, w=20, y=1023, h=5, set=1, RAM 8'h00.
  - Single RMW at addr 524287 with wdata 8'hFC.
  - No address beyond 524287 is accessed; done follows.
- **Degenerate and back-to-back:**
  - w=0 request: done at T1, with no mem_re or mem_we.
  - A second req_valid held during a busy request: it is not accepted until req_ready rises after done.
- **Reset mid-operation:** assert Reset in the READ cycle of a partial byte.
  - No MODIFY write follows.
  - No done pulse.
  - Next cycle: req_ready=1, busy=0.
  - A new request is then processed normally.

Source files
------------

// File: rtl/map_painter.sv
// Rectangle fill engine for the byte-packed terrain map (512 bytes x 1024 rows, LSB = leftmost pixel).
// Fully covered bytes are written in one cycle; partially covered bytes are read, merged and written back.
module map_painter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_x,
  input  logic [9:0]  req_y,
  input  logic [11:0] req_w,
  input  logic [9:0]  req_h,
  input  logic        req_set,
  output logic [18:0] mem_addr,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on any rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so at most one request is ever in flight.

  // CHECK performs the byte operation of the current byte in its own cycle: a full
  // byte is written there, a partial byte issues its read there and merges in MODIFY.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_MODIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [8:0]  col, col_first, col_last, col_nxt;
  logic [9:0]  row, row_last, row_nxt;
  logic [2:0]  lo_first, hi_last;
  logic        set_r;

  logic [12:0] x_end;
  logic [10:0] y_end;
  logic [11:0] x_end_m1, lx;
  logic [9:0]  y_end_m1, ly;
  logic        req_empty;
  logic        accept, advance;
  logic        last_col, last_row;
  logic [2:0]  lo, hi;
  logic [7:0]  mask;

  // Clipping sums carry one extra bit so the right/bottom edge can never wrap.
  assign x_end     = {1'b0, req_x} + {1'b0, req_w};
  assign y_end     = {1'b0, req_y} + {1'b0, req_h};
  assign x_end_m1  = x_end[11:0] - 12'd1;
  assign y_end_m1  = y_end[9:0] - 10'd1;
  assign lx        = x_end[12] ? 12'hFFF : x_end_m1;
  assign ly        = y_end[10] ? 10'h3FF : y_end_m1;
  assign req_empty = (req_w == 12'd0) || (req_h == 10'd0);

  assign last_col = (col == col_last);
  assign last_row = (row == row_last);
  assign lo       = (col == col_first) ? lo_first : 3'd0;
  assign hi       = last_col ? hi_last : 3'd7;

  always_comb begin
    mask = 8'h00;
    for (int i = 0; i < 8; i++) begin
      mask[i] = (i >= int'(lo)) && (i <= int'(hi));
    end
  end

  always_comb begin
    if (last_col) begin
      col_nxt = col_first;
      row_nxt = row + 10'd1;
    end else begin
      col_nxt = col + 9'd1;
      row_nxt = row;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      col       <= 9'd0;
      col_first <= 9'd0;
      col_last  <= 9'd0;
      row       <= 10'd0;
      row_last  <= 10'd0;
      lo_first  <= 3'd0;
      hi_last   <= 3'd0;
      set_r     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        col       <= req_x[11:3];
        col_first <= req_x[11:3];
        col_last  <= lx[11:3];
        lo_first  <= req_x[2:0];
        hi_last   <= lx[2:0];
        row       <= req_y;
        row_last  <= ly;
        set_r     <= req_set;
      end else if (advance) begin
        col <= col_nxt;
        row <= row_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    mem_addr  = 19'd0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = req_empty ? S_DONE : S_CHECK;
        end
      end
      S_CHECK: begin
        mem_addr = {row, col};
        if (mask == 8'hFF) begin
          mem_we    = 1'b1;
          mem_wdata = {8{set_r}};
          advance   = 1'b1;
        end else begin
          mem_re    = 1'b1;
          state_nxt = S_MODIFY;
        end
      end
      S_MODIFY: begin
        mem_addr  = {row, col};
        mem_we    = 1'b1;
        mem_wdata = set_r ? (mem_rdata | mask) : (mem_rdata & ~mask);
        advance   = 1'b1;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (advance) begin
      state_nxt = (last_col && last_row) ? S_DONE : S_CHECK;
    end
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_map_painter.sv
// Directed and randomized bench for map_painter: a sparse map RAM model, a pixel-level
// reference that queues expected writes, and a monitor that pops and compares them.
module tb_map_painter;

  logic        Clk;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_x;
  logic [9:0]  req_y;
  logic [11:0] req_w;
  logic [9:0]  req_h;
  logic        req_set;
  logic [18:0] mem_addr;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  map_painter dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_w     (req_w),
    .req_h     (req_h),
    .req_set   (req_set),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  // ---------------- counters and scoreboard ----------------
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_reads  = 0;
  int          n_done   = 0;
  logic [26:0] exp_q[$];
  logic [7:0]  ram [int];

  function automatic logic [7:0] rd(input int a);
    if (ram.exists(a)) return ram[a];
    return 8'h00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Map RAM: one-cycle read latency, write on the strobe edge.
  always @(posedge Clk) begin
    if (mem_re === 1'b1) mem_rdata <= rd(int'(mem_addr));
    if (mem_we === 1'b1) ram[int'(mem_addr)] = mem_wdata;
  end

  // Monitor: every write is popped against the expected queue.
  always @(negedge Clk) begin
    logic [26:0] e;
    if (done === 1'b1) n_done++;
    if (mem_re === 1'b1) begin
      n_reads++;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        check("read_addr", 32'(mem_addr), 32'(e[26:8]));
      end
    end
    if (mem_we === 1'b1) begin
      check("strobe_excl", 32'(mem_re), 32'd0);
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(e[26:8]));
        check("write_data", 32'(mem_wdata), 32'(e[7:0]));
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic model_req(input int x, input int y, input int w, input int h, input bit s,
                           output int cyc, output int rds);
    int lx, ly, e, a, p;
    logic [7:0] m, old, d;
    logic [18:0] a19;
    cyc = 0;
    rds = 0;
    if (w == 0 || h == 0) return;
    e = x + w; if (e > 4096) e = 4096; lx = e - 1;
    e = y + h; if (e > 1024) e = 1024; ly = e - 1;
    for (int r = y; r <= ly; r++) begin
      for (int c = x / 8; c <= lx / 8; c++) begin
        m = 8'h00;
        for (int i = 0; i < 8; i++) begin
          p = c * 8 + i;
          if (p >= x && p <= lx) m[i] = 1'b1;
        end
        a = r * 512 + c;
        if (m == 8'hFF) begin
          d = s ? 8'hFF : 8'h00;
          cyc += 1;
        end else begin
          old = rd(a);
          d = s ? (old | m) : (old & ~m);
          cyc += 2;
          rds++;
        end
        a19 = a[18:0];
        exp_q.push_back({a19, d});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int x, input int y, input int w, input int h, input bit s);
    int g = 0;
    while (req_ready !== 1'b1 && g < 200) begin
      @(negedge Clk);
      g++;
    end
    check("ready_before_drive", 32'(req_ready), 32'd1);
    req_x     = 12'(x);
    req_y     = 10'(y);
    req_w     = 12'(w);
    req_h     = 10'(h);
    req_set   = s;
    req_valid = 1'b1;
  endtask

  // Called at the negedge of T1; returns at the negedge after done.
  task automatic wait_done(input string tag, input int cyc, input int rds, input int r0, input int left);
    int k = 1;
    if (cyc > 0) begin
      check({tag, "_busy_t1"}, 32'(busy), 32'd1);
      check({tag, "_ready_t1"}, 32'(req_ready), 32'd0);
    end
    while (done !== 1'b1 && k < cyc + 50) begin
      @(negedge Clk);
      k++;
    end
    check({tag, "_done_cycle"}, 32'(k), 32'(cyc + 1));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    check({tag, "_reads"}, 32'(n_reads - r0), 32'(rds));
    check({tag, "_queue_left"}, 32'(exp_q.size()), 32'(left));
    @(negedge Clk);
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic finish_req(input string tag, input int cyc, input int rds);
    int r0 = n_reads;
    @(negedge Clk);
    req_valid = 1'b0;
    req_x     = 12'($urandom);
    req_y     = 10'($urandom);
    req_w     = 12'($urandom);
    req_h     = 10'($urandom);
    req_set   = 1'($urandom);
    wait_done(tag, cyc, rds, r0, 0);
  endtask

  task automatic run_req(input string tag, input int x, input int y, input int w, input int h, input bit s);
    int cyc, rds;
    model_req(x, y, w, h, s, cyc, rds);
    drive_req(x, y, w, h, s);
    finish_req(tag, cyc, rds);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int ca, ra, cb, rb, r0, d0;
    int x, y, w, h;
    bit s;
    Reset = 1'b1;
    req_valid = 1'b0;
    req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_set = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_re", 32'(mem_re), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // Single pixel set over a pre-loaded byte
    ram[1537] = 8'h81;
    run_req("single_px", 10, 3, 1, 1, 1'b1);
    check("single_px_ram", 32'(rd(1537)), 32'h85);

    // Aligned clear of two full bytes on two rows
    ram[2] = 8'h5A; ram[3] = 8'hA5; ram[514] = 8'hFF; ram[515] = 8'h3C;
    run_req("aligned_clr", 16, 0, 16, 2, 1'b0);

    // Span straddling a byte boundary
    run_req("straddle", 5, 0, 8, 1, 1'b1);
    check("straddle_b0", 32'(rd(0)), 32'hE0);
    check("straddle_b1", 32'(rd(1)), 32'h1F);

    // Clipped at the bottom-right corner of the map
    run_req("clip", 4090, 1023, 20, 5, 1'b1);
    check("clip_ram", 32'(rd(524287)), 32'hFC);

    // Degenerate requests
    run_req("w_zero", 100, 10, 0, 4, 1'b1);
    run_req("h_zero", 100, 10, 8, 0, 1'b1);

    // Back-to-back: second request held valid while the first is busy
    model_req(16, 0, 16, 2, 1'b1, ca, ra);
    drive_req(16, 0, 16, 2, 1'b1);
    r0 = n_reads;
    @(negedge Clk);
    req_x = 12'd40; req_y = 10'd5; req_w = 12'd8; req_h = 10'd1; req_set = 1'b1;
    model_req(40, 5, 8, 1, 1'b1, cb, rb);
    wait_done("b2b_a", ca, ra, r0, 1);
    finish_req("b2b_b", cb, rb);
    check("b2b_b_ram", 32'(rd(2565)), 32'hFF);

    // Reset in the READ cycle of a partial byte
    drive_req(1, 7, 2, 1, 1'b1);
    @(negedge Clk);
    req_valid = 1'b0;
    check("rstop_read_cycle", 32'(mem_re), 32'd1);
    d0 = n_done;
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("rstop_ready", 32'(req_ready), 32'd1);
    check("rstop_busy", 32'(busy), 32'd0);
    check("rstop_we", 32'(mem_we), 32'd0);
    repeat (3) @(negedge Clk);
    check("rstop_no_done", 32'(n_done), 32'(d0));
    check("rstop_ram", 32'(rd(3584)), 32'd0);
    ram[3585] = 8'hF0;
    run_req("after_rst", 6, 7, 6, 1, 1'b0);

    // Randomized rectangles over random map contents
    for (int t = 0; t < 6; t++) begin
      x = $urandom_range(0, 4095);
      y = $urandom_range(0, 1023);
      w = $urandom_range(0, 28);
      h = $urandom_range(0, 3);
      s = 1'($urandom_range(0, 1));
      if (t == 0) x = $urandom_range(4070, 4095);
      for (int r = y; r < y + 4 && r < 1024; r++)
        for (int c = x / 8; c <= (x + 28) / 8 && c < 512; c++)
          ram[r * 512 + c] = 8'($urandom_range(0, 255));
      run_req($sformatf("rand%0d", t), x, y, w, h, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
